// File: rtl/proc_dpath_muldiv_iter.sv
// Iterative RV32M multiply/divide unit for the X stage: shift-add MUL and restoring
// division, fixed NBITS-cycle latency, val/rdy request/response with squash.
module proc_dpath_muldiv_iter #(
  parameter int NBITS = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_val,
  output logic             req_rdy,
  input  logic [2:0]       req_fn,
  input  logic [NBITS-1:0] req_in0,
  input  logic [NBITS-1:0] req_in1,
  input  logic             squash,
  output logic             resp_val,
  input  logic             resp_rdy,
  output logic [NBITS-1:0] resp_result
);

  localparam int CW = $clog2(NBITS + 1);
  localparam logic [2:0] FN_MUL  = 3'd0;
  localparam logic [2:0] FN_DIV  = 3'd1;
  localparam logic [2:0] FN_DIVU = 3'd2;
  localparam logic [2:0] FN_REM  = 3'd3;
  localparam logic [2:0] FN_REMU = 3'd4;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [2:0]       fn_q;
  logic [NBITS-1:0] a_q;     // MUL: shifting multiplicand; DIV: dividend in / quotient out
  logic [NBITS-1:0] b_q;     // MUL: shifting multiplier;   DIV: divisor magnitude
  logic [NBITS-1:0] in0_q;
  logic [NBITS:0]   acc_q;   // MUL: product accumulator;   DIV: partial remainder
  logic             neg_quo_q, neg_rem_q;
  logic             fire;

  // Signed ops work on magnitudes; the sign fix-up is applied on the way out.
  logic             sgn_in;
  logic [NBITS-1:0] abs0, abs1;
  assign sgn_in = (req_fn == FN_DIV) || (req_fn == FN_REM);
  assign abs0   = (sgn_in && req_in0[NBITS-1]) ? -req_in0 : req_in0;
  assign abs1   = (sgn_in && req_in1[NBITS-1]) ? -req_in1 : req_in1;

  logic [NBITS:0]   rem_sh;
  logic             rem_ge;
  assign rem_sh = {acc_q[NBITS-1:0], a_q[NBITS-1]};
  assign rem_ge = rem_sh >= {1'b0, b_q};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    req_rdy  = 1'b0;
    resp_val = 1'b0;
    case (state_q)
      IDLE: begin
        req_rdy = reset && !squash;
        if (req_val && req_rdy) state_d = CALC;
      end
      CALC: begin
        if (squash)                  state_d = IDLE;
        else if (cnt_q == CW'(1))    state_d = DONE;
      end
      DONE: begin
        // A squashed result must never look like a completed transfer.
        resp_val = !squash;
        if (squash || resp_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign fire = req_val && req_rdy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      fn_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      in0_q     <= '0;
      acc_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else if (fire) begin
      cnt_q     <= CW'(NBITS);
      fn_q      <= req_fn;
      a_q       <= abs0;
      b_q       <= abs1;
      in0_q     <= req_in0;
      acc_q     <= '0;
      neg_quo_q <= sgn_in && (req_in0[NBITS-1] ^ req_in1[NBITS-1]);
      neg_rem_q <= sgn_in && req_in0[NBITS-1];
    end else if (state_q == CALC) begin
      cnt_q <= cnt_q - CW'(1);
      if (fn_q == FN_MUL) begin
        // Carry into acc_q[NBITS] is don't-care; only the low NBITS are returned.
        acc_q <= acc_q + {1'b0, {NBITS{b_q[0]}} & a_q};
        a_q   <= a_q << 1;
        b_q   <= b_q >> 1;
      end else begin
        acc_q <= rem_ge ? (rem_sh - {1'b0, b_q}) : rem_sh;
        a_q   <= {a_q[NBITS-2:0], rem_ge};
      end
    end
  end

  logic             div0;
  logic [NBITS-1:0] rem_mag, res;
  assign div0    = (b_q == '0);
  assign rem_mag = acc_q[NBITS-1:0];

  always_comb begin
    res = '0;
    case (fn_q)
      FN_MUL:          res = acc_q[NBITS-1:0];
      FN_DIV, FN_DIVU: res = div0 ? '1 : (neg_quo_q ? -a_q : a_q);
      FN_REM, FN_REMU: res = div0 ? in0_q : (neg_rem_q ? -rem_mag : rem_mag);
      default:         res = '0;
    endcase
    resp_result = (state_q == DONE) ? res : '0;
  end

endmodule

// File: tb/tb_proc_dpath_muldiv_iter.sv
// Randomized + directed bench for proc_dpath_muldiv_iter with a queue scoreboard
// fed by the driver and drained by an independent response monitor.
module tb_proc_dpath_muldiv_iter;
  localparam int NBITS = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             req_val, req_rdy, squash, resp_val, resp_rdy;
  logic [2:0]       req_fn;
  logic [NBITS-1:0] req_in0, req_in1, resp_result;

  proc_dpath_muldiv_iter #(.NBITS(NBITS)) dut (
    .clk(clk), .reset(reset), .req_val(req_val), .req_rdy(req_rdy), .req_fn(req_fn),
    .req_in0(req_in0), .req_in1(req_in1), .squash(squash), .resp_val(resp_val),
    .resp_rdy(resp_rdy), .resp_result(resp_result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] res; int fc; } exp_t;
  exp_t exp_q[$];
  bit   head_seen = 0;
  int   errors = 0, checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Reference: RV32M semantics from plain arithmetic.
  function automatic logic [31:0] model(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (fn)
      3'd0: return a * b;
      3'd1: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        r = sa / sb; return 32'(r);
      end
      3'd2: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd3: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        r = sa % sb; return 32'(r);
      end
      3'd4: return (b == 0) ? a : a % b;
      default: return 32'h0;
    endcase
  endfunction

  // Monitor: latency on first sight of a response, value on each transfer.
  always @(negedge clk) begin
    if (reset === 1'b1 && resp_val === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_resp: got result %h with nothing outstanding", resp_result);
      end else begin
        if (!head_seen) begin
          head_seen = 1;
          chk("latency", 32'(cyc - exp_q[0].fc), 32'(NBITS + 1));
        end
        if (resp_rdy) begin
          chk("result", resp_result, exp_q[0].res);
          void'(exp_q.pop_front());
          head_seen = 0;
        end
      end
    end
  end

  task automatic issue(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b, input bit rnd_rdy);
    int n = 0;
    @(posedge clk); #1;
    req_val = 1; req_fn = fn; req_in0 = a; req_in1 = b;
    @(negedge clk);
    while (req_rdy !== 1'b1 && n < 300) begin
      @(posedge clk); #1;
      if (rnd_rdy) resp_rdy = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
    end
    if (req_rdy !== 1'b1) begin
      checks++; errors++;
      $display("FAIL issue_timeout: req_rdy %b after %0d cycles, required 1", req_rdy, n);
      req_val = 0;
      return;
    end
    exp_q.push_back('{model(fn, a, b), cyc});
    @(posedge clk); #1;
    req_val = 0; req_fn = 3'($urandom); req_in0 = $urandom; req_in1 = $urandom;
  endtask

  task automatic wait_resp();
    int n = 0;
    @(negedge clk);
    while (resp_val !== 1'b1 && n < 80) begin @(negedge clk); n++; end
    if (resp_val !== 1'b1) begin
      checks++; errors++;
      $display("FAIL wait_resp_timeout: resp_val %b, required 1", resp_val);
    end
  endtask

  task automatic drain();
    int n = 0;
    resp_rdy = 1;
    while (exp_q.size() > 0 && n < 300) begin @(negedge clk); n++; end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  logic [2:0]  d_fn [12] = '{3'd0, 3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd1, 3'd3, 3'd4, 3'd1, 3'd3, 3'd5};
  logic [31:0] d_a  [12] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                             32'hFFFF_FFF9, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000,
                             32'h8000_0000, 32'd1234};
  logic [31:0] d_b  [12] = '{32'd6, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd2, 32'd2, 32'd0, 32'd0,
                             32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd77};

  initial begin
    logic [31:0] r0, a, b;
    reset = 0; req_val = 0; squash = 0; resp_rdy = 1;
    req_fn = 0; req_in0 = 0; req_in1 = 0;
    #12;
    chk("rst_req_rdy", {31'd0, req_rdy}, 32'd0);
    chk("rst_resp_val", {31'd0, resp_val}, 32'd0);
    chk("rst_result", resp_result, 32'd0);
    @(posedge clk); #2 reset = 1;
    @(negedge clk);
    chk("post_rst_req_rdy", {31'd0, req_rdy}, 32'd1);

    for (int i = 0; i < 12; i++) issue(d_fn[i], d_a[i], d_b[i], 0);
    drain();

    // Backpressure: result held for 10 cycles, then a single transfer.
    resp_rdy = 0;
    issue(3'd0, 32'd123, 32'd456, 0);
    wait_resp();
    r0 = resp_result;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_resp_val", {31'd0, resp_val}, 32'd1);
      chk("bp_result", resp_result, r0);
      chk("bp_req_rdy", {31'd0, req_rdy}, 32'd0);
    end
    @(posedge clk); #1 resp_rdy = 1;
    @(negedge clk);
    chk("xfer_req_rdy_same", {31'd0, req_rdy}, 32'd0);
    @(negedge clk);
    chk("xfer_req_rdy_next", {31'd0, req_rdy}, 32'd1);
    chk("xfer_resp_val_next", {31'd0, resp_val}, 32'd0);

    // Squash in CALC cycle 5, then a fresh MUL.
    issue(3'd1, 32'd1000, 32'd7, 0);
    repeat (4) @(posedge clk);
    #1 squash = 1;
    @(negedge clk);
    chk("sq_calc_resp_val", {31'd0, resp_val}, 32'd0);
    @(posedge clk); #1 squash = 0;
    void'(exp_q.pop_back()); head_seen = 0;
    @(negedge clk);
    chk("sq_calc_idle", {31'd0, req_rdy}, 32'd1);
    repeat (40) @(negedge clk);
    issue(3'd0, 32'd3, 32'd3, 0);
    drain();

    // Squash in IDLE blocks a same-cycle fire.
    @(posedge clk); #1 squash = 1; req_val = 1; req_fn = 3'd0;
    @(negedge clk);
    chk("sq_idle_req_rdy", {31'd0, req_rdy}, 32'd0);
    @(posedge clk); #1 squash = 0; req_val = 0;
    @(negedge clk);
    chk("sq_idle_no_fire", {31'd0, req_rdy}, 32'd1);

    // Squash together with resp_rdy in DONE: no transfer.
    resp_rdy = 0;
    issue(3'd4, 32'd100, 32'd9, 0);
    wait_resp();
    @(posedge clk); #1 squash = 1; resp_rdy = 1;
    void'(exp_q.pop_back()); head_seen = 0;
    @(negedge clk);
    chk("sq_done_resp_val", {31'd0, resp_val}, 32'd0);
    @(posedge clk); #1 squash = 0;
    @(negedge clk);
    chk("sq_done_idle", {31'd0, req_rdy}, 32'd1);

    // Asynchronous reset mid-CALC.
    issue(3'd2, 32'hDEAD_BEEF, 32'd13, 0);
    repeat (10) @(posedge clk);
    #3 reset = 0;
    #1;
    chk("rst_calc_req_rdy", {31'd0, req_rdy}, 32'd0);
    chk("rst_calc_resp_val", {31'd0, resp_val}, 32'd0);
    exp_q.delete(); head_seen = 0;
    @(posedge clk); #3 reset = 1;
    @(negedge clk);
    chk("rst_calc_release", {31'd0, req_rdy}, 32'd1);
    repeat (40) @(negedge clk);

    // Asynchronous reset while holding a result in DONE.
    resp_rdy = 0;
    issue(3'd0, 32'd11, 32'd13, 0);
    wait_resp();
    #2 reset = 0;
    #1;
    chk("rst_done_resp_val", {31'd0, resp_val}, 32'd0);
    chk("rst_done_result", resp_result, 32'd0);
    chk("rst_done_req_rdy", {31'd0, req_rdy}, 32'd0);
    exp_q.delete(); head_seen = 0;
    @(posedge clk); #3 reset = 1; resp_rdy = 1;
    @(negedge clk);
    chk("rst_done_release", {31'd0, req_rdy}, 32'd1);
    repeat (40) @(negedge clk);

    // Random traffic with random backpressure.
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       begin b = 32'hFFFF_FFFF; if ($urandom_range(0, 1) == 1) a = 32'h8000_0000; end
        2:       b = 32'($urandom_range(1, 16));
        default: b = $urandom;
      endcase
      issue(3'($urandom_range(0, 7)), a, b, 1);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
